led_shift_receiver: RTL

Synthesizable receiver for the three-wire LED serial link (data, shift clock, latch) driven by `top`. It sits directly downstream of `top`'s `leddata`/`ledclk`/`ledlatch` pins and behaves like a 74HC595-style shift/latch register, but runs in its own system clock domain. It oversamples the link, shifts bits in on shift-clock rising edges and presents the latched word in parallel. It also flags malformed frames. It is used both as a board-side decoder and as a self-checking monitor in benches.

---
 rtl/led_shift_receiver.sv | 107 ++++++++++
 1 files changed

// File: rtl/led_shift_receiver.sv
// Oversampling receiver for the three-wire LED link (data / shift clock / latch).
// Behaves like a 74HC595 shift/latch register in the local clk domain and flags malformed frames.
module led_shift_receiver #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CW         = $clog2(2*WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_data,
    input  logic             ser_clk,
    input  logic             ser_latch,
    output logic [WIDTH-1:0] q,
    output logic             frame_valid,
    output logic [CW-1:0]    bit_count,
    output logic             short_frame,
    output logic             long_frame
);

    localparam int unsigned SAT = 2*WIDTH;

    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic                   clk_dly_q;
    logic                   latch_dly_q;

    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             fv_q,    fv_d;
    logic             short_q, short_d;
    logic             long_q,  long_d;

    logic data_s;
    logic shift_ev;
    logic latch_ev;

    // Per-line synchronizers plus one delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_q  <= '0;
            clk_sync_q   <= '0;
            latch_sync_q <= '0;
            clk_dly_q    <= 1'b0;
            latch_dly_q  <= 1'b0;
        end else begin
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ser_data};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], ser_latch};
            clk_dly_q    <= clk_sync_q[SYNC_STAGES-1];
            latch_dly_q  <= latch_sync_q[SYNC_STAGES-1];
        end
    end

    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign shift_ev = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
    assign latch_ev = latch_sync_q[SYNC_STAGES-1] & ~latch_dly_q;

    // Shift applies before latch so a coincident latch captures the new bit
    always_comb begin
        sreg_d  = sreg_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        fv_d    = 1'b0;
        short_d = short_q;
        long_d  = long_q;
        if (shift_ev) begin
            sreg_d = {sreg_q[WIDTH-2:0], data_s};
            if (cnt_q != CW'(SAT)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (latch_ev) begin
            word_d  = sreg_d;
            fv_d    = 1'b1;
            short_d = (cnt_d < CW'(WIDTH));
            long_d  = (cnt_d > CW'(WIDTH));
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    assign q           = word_q;
    assign frame_valid = fv_q;
    assign bit_count   = cnt_q;
    assign short_frame = short_q;
    assign long_frame  = long_q;

endmodule
